// File: rtl/alarm_bank_pkg.sv
// Shared types and helpers for the alarm bank: channel state, BCD field widths,
// and the alarm-time validity check used on configuration writes.
package alarm_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZED = 2'd3
    } ch_state_t;

    localparam int HH_W = 8;
    localparam int MM_W = 8;
    localparam int SS_W = 8;

    // hh_mm packed BCD: every nibble a decimal digit, hh <= 23, mm <= 59
    function automatic logic bcd_time_valid(input logic [HH_W+MM_W-1:0] t);
        logic [HH_W-1:0] hh;
        logic [MM_W-1:0] mm;
        hh = t[HH_W+MM_W-1:MM_W];
        mm = t[MM_W-1:0];
        return (hh[7:4] <= 4'd9) && (hh[3:0] <= 4'd9) &&
               (mm[7:4] <= 4'd9) && (mm[3:0] <= 4'd9) &&
               (hh <= 8'h23) && (mm <= 8'h59);
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// Purpose: one alarm channel -- stored time/day mask, IDLE/ARMED/RINGING/SNOOZED FSM, saturating counters.
// Latency: state_nxt is combinational from current state and this cycle's inputs; state updates next edge.
// Backpressure: none; tick, snooze, dismiss and write strobes are single-cycle pulses acted on immediately.
module alarm_channel
    import alarm_bank_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [23:0]      time_bcd,
    input  logic [2:0]       weekday,
    input  logic             wr_en,
    input  logic [15:0]      wr_time,
    input  logic [6:0]       wr_days,
    input  logic             wr_arm,
    input  logic             snooze,
    input  logic             dismiss,
    output ch_state_t        state_nxt
);

    localparam int SNOOZE_TICKS = SNOOZE_MINUTES * 60;
    localparam int RW = $clog2(RING_SECONDS + 1);
    localparam int SW = $clog2(SNOOZE_TICKS + 1);
    localparam logic [RW-1:0] RING_LIM = RW'(RING_SECONDS);
    localparam logic [SW-1:0] SNZ_LIM  = SW'(SNOOZE_TICKS);
    localparam logic [2:0]    SNZ_MAX  = 3'(MAX_SNOOZE);

    ch_state_t       state;
    logic [15:0]     alm_time, alm_time_nxt;
    logic [6:0]      alm_days, alm_days_nxt;
    logic [RW-1:0]   ring_cnt, ring_cnt_nxt;
    logic [SW-1:0]   snz_cnt, snz_cnt_nxt;
    logic [2:0]      snz_num, snz_num_nxt;
    logic [7:0]      days_ext;
    logic            trigger;

    // weekday 7 is not a real day; the padded bit keeps it from ever matching
    assign days_ext = {1'b0, alm_days};
    assign trigger  = tick_1hz && (time_bcd[23:SS_W] == alm_time) &&
                      (time_bcd[SS_W-1:0] == '0) && days_ext[weekday];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            alm_time <= '0;
            alm_days <= '0;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            snz_num  <= '0;
        end else begin
            state    <= state_nxt;
            alm_time <= alm_time_nxt;
            alm_days <= alm_days_nxt;
            ring_cnt <= ring_cnt_nxt;
            snz_cnt  <= snz_cnt_nxt;
            snz_num  <= snz_num_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        alm_time_nxt = alm_time;
        alm_days_nxt = alm_days;
        ring_cnt_nxt = ring_cnt;
        snz_cnt_nxt  = snz_cnt;
        snz_num_nxt  = snz_num;

        if (wr_en) begin
            alm_time_nxt = wr_time;
            alm_days_nxt = wr_days;
            state_nxt    = (wr_arm && bcd_time_valid(wr_time)) ? ST_ARMED : ST_IDLE;
            ring_cnt_nxt = '0;
            snz_cnt_nxt  = '0;
            snz_num_nxt  = '0;
        end else begin
            unique case (state)
                ST_ARMED: begin
                    if (trigger) begin
                        state_nxt    = ST_RINGING;
                        ring_cnt_nxt = '0;
                        snz_num_nxt  = '0;
                    end
                end
                ST_RINGING: begin
                    if (dismiss) begin
                        state_nxt = ST_ARMED;
                    end else if (snooze) begin
                        if (snz_num < SNZ_MAX) begin
                            state_nxt   = ST_SNOOZED;
                            snz_num_nxt = snz_num + 3'd1;
                            snz_cnt_nxt = '0;
                        end else begin
                            state_nxt = ST_ARMED;
                        end
                    end else if (tick_1hz) begin
                        if (ring_cnt != RING_LIM) ring_cnt_nxt = ring_cnt + 1'b1;
                        if (ring_cnt_nxt == RING_LIM) state_nxt = ST_ARMED;
                    end
                end
                ST_SNOOZED: begin
                    if (dismiss) begin
                        state_nxt = ST_ARMED;
                    end else if (tick_1hz) begin
                        if (snz_cnt != SNZ_LIM) snz_cnt_nxt = snz_cnt + 1'b1;
                        if (snz_cnt_nxt == SNZ_LIM) begin
                            state_nxt    = ST_RINGING;
                            ring_cnt_nxt = '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Purpose: bank of independent alarm channels with a lowest-index ringing priority encoder.
// Latency: outputs registered from next state, so a triggering tick shows on ring one clk later.
// Backpressure: none; writes to out-of-range indices are dropped, all pulses are accepted every cycle.
module alarm_bank
    import alarm_bank_pkg::*;
#(
    parameter int NUM_ALARMS     = 4,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    parameter int MAX_SNOOZE     = 3,
    localparam int IDXW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic [23:0]           time_bcd,
    input  logic [2:0]            weekday,
    input  logic                  wr_en,
    input  logic [IDXW-1:0]       wr_idx,
    input  logic [15:0]           wr_time,
    input  logic [6:0]            wr_days,
    input  logic                  wr_arm,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic                  ring,
    output logic [IDXW-1:0]       ring_id,
    output logic [NUM_ALARMS-1:0] armed_mask,
    output logic [NUM_ALARMS-1:0] snoozed_mask
);

    localparam logic [IDXW:0] NUM_CH = (IDXW + 1)'(NUM_ALARMS);

    ch_state_t             st_nxt [NUM_ALARMS];
    logic                  wr_ok;
    logic                  ring_d;
    logic [IDXW-1:0]       ring_id_d;
    logic [NUM_ALARMS-1:0] armed_d;
    logic [NUM_ALARMS-1:0] snoozed_d;

    assign wr_ok = wr_en && ({1'b0, wr_idx} < NUM_CH);

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        alarm_channel #(
            .RING_SECONDS   (RING_SECONDS),
            .SNOOZE_MINUTES (SNOOZE_MINUTES),
            .MAX_SNOOZE     (MAX_SNOOZE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick_1hz  (tick_1hz),
            .time_bcd  (time_bcd),
            .weekday   (weekday),
            .wr_en     (wr_ok && (wr_idx == IDXW'(i))),
            .wr_time   (wr_time),
            .wr_days   (wr_days),
            .wr_arm    (wr_arm),
            .snooze    (snooze),
            .dismiss   (dismiss),
            .state_nxt (st_nxt[i])
        );
    end

    // Encode from next state so the registered outputs land with the state change
    always_comb begin
        ring_d    = 1'b0;
        ring_id_d = '0;
        armed_d   = '0;
        snoozed_d = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            armed_d[i]   = (st_nxt[i] != ST_IDLE);
            snoozed_d[i] = (st_nxt[i] == ST_SNOOZED);
            if ((st_nxt[i] == ST_RINGING) && !ring_d) begin
                ring_d    = 1'b1;
                ring_id_d = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring         <= 1'b0;
            ring_id      <= '0;
            armed_mask   <= '0;
            snoozed_mask <= '0;
        end else begin
            ring         <= ring_d;
            ring_id      <= ring_id_d;
            armed_mask   <= armed_d;
            snoozed_mask <= snoozed_d;
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Alarm bank bench: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a second-counting channel model.
module tb_alarm_bank;

    localparam int N  = 4;
    localparam int RS = 60;
    localparam int SM = 5;
    localparam int MS = 3;
    localparam int IW = 2;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick_1hz = 1'b0;
    logic [23:0]   time_bcd = '0;
    logic [2:0]    weekday = 3'd2;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_idx = '0;
    logic [15:0]   wr_time = '0;
    logic [6:0]    wr_days = '0;
    logic          wr_arm = 1'b0;
    logic          snooze = 1'b0;
    logic          dismiss = 1'b0;
    logic          ring;
    logic [IW-1:0] ring_id;
    logic [N-1:0]  armed_mask;
    logic [N-1:0]  snoozed_mask;

    alarm_bank #(
        .NUM_ALARMS     (N),
        .RING_SECONDS   (RS),
        .SNOOZE_MINUTES (SM),
        .MAX_SNOOZE     (MS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_1hz     (tick_1hz),
        .time_bcd     (time_bcd),
        .weekday      (weekday),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_time      (wr_time),
        .wr_days      (wr_days),
        .wr_arm       (wr_arm),
        .snooze       (snooze),
        .dismiss      (dismiss),
        .ring         (ring),
        .ring_id      (ring_id),
        .armed_mask   (armed_mask),
        .snoozed_mask (snoozed_mask)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: per channel a state, stored alarm, seconds spent ringing/snoozed, snoozes used
    int m_st [N];
    int m_tm [N];
    int m_days [N];
    int m_rung [N];
    int m_snz_el [N];
    int m_snz_used [N];
    int hh = 12, mm = 0, ss = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bcd_ok(input logic [15:0] t);
        int d [4];
        for (int k = 0; k < 4; k++) d[k] = int'(t[k*4 +: 4]);
        if (d[0] > 9 || d[1] > 9 || d[2] > 9 || d[3] > 9) return 1'b0;
        return ((d[3] * 10 + d[2]) < 24) && ((d[1] * 10 + d[0]) < 60);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_st[c] = M_IDLE; m_tm[c] = 0; m_days[c] = 0;
            m_rung[c] = 0; m_snz_el[c] = 0; m_snz_used[c] = 0;
        end
    endtask

    task automatic model_step();
        bit at_alarm;
        for (int c = 0; c < N; c++) begin
            at_alarm = tick_1hz && (int'(time_bcd[23:8]) == m_tm[c]) && (time_bcd[7:0] == 8'h00) &&
                       (int'(weekday) < 7) && (((m_days[c] >> weekday) & 1) == 1);
            if (wr_en && int'(wr_idx) < N && int'(wr_idx) == c) begin
                m_tm[c] = int'(wr_time); m_days[c] = int'(wr_days);
                m_st[c] = (wr_arm && bcd_ok(wr_time)) ? M_ARMED : M_IDLE;
                m_rung[c] = 0; m_snz_el[c] = 0; m_snz_used[c] = 0;
            end else if (m_st[c] == M_ARMED) begin
                if (at_alarm) begin m_st[c] = M_RING; m_rung[c] = 0; m_snz_used[c] = 0; end
            end else if (m_st[c] == M_RING) begin
                if (dismiss) m_st[c] = M_ARMED;
                else if (snooze) begin
                    if (m_snz_used[c] < MS) begin
                        m_st[c] = M_SNZ; m_snz_used[c]++; m_snz_el[c] = 0;
                    end else m_st[c] = M_ARMED;
                end else if (tick_1hz) begin
                    m_rung[c]++;
                    if (m_rung[c] >= RS) m_st[c] = M_ARMED;
                end
            end else if (m_st[c] == M_SNZ) begin
                if (dismiss) m_st[c] = M_ARMED;
                else if (tick_1hz) begin
                    m_snz_el[c]++;
                    if (m_snz_el[c] >= SM * 60) begin m_st[c] = M_RING; m_rung[c] = 0; end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    initial begin
        int e_ring, e_id, e_arm, e_snz;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                e_ring = 0; e_id = 0; e_arm = 0; e_snz = 0;
                for (int c = 0; c < N; c++) begin
                    if (m_st[c] == M_RING && e_ring == 0) begin e_ring = 1; e_id = c; end
                    if (m_st[c] != M_IDLE) e_arm += (1 << c);
                    if (m_st[c] == M_SNZ) e_snz += (1 << c);
                end
                check("cyc_ring", int'(ring), e_ring);
                check("cyc_ring_id", int'(ring_id), e_id);
                check("cyc_armed", int'(armed_mask), e_arm);
                check("cyc_snoozed", int'(snoozed_mask), e_snz);
            end
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic set_time(input int h, input int m, input int s);
        hh = h; mm = m; ss = s;
        time_bcd = {to_bcd(hh), to_bcd(mm), to_bcd(ss)};
    endtask

    task automatic advance();
        ss++;
        if (ss == 60) begin ss = 0; mm++; end
        if (mm == 60) begin mm = 0; hh++; end
        if (hh == 24) begin hh = 0; weekday = 3'((int'(weekday) + 1) % 7); end
        time_bcd = {to_bcd(hh), to_bcd(mm), to_bcd(ss)};
    endtask

    task automatic do_tick();
        advance();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) do_tick();
    endtask

    task automatic write_ch(input int idx, input logic [15:0] t, input logic [6:0] d, input logic arm);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_time = t; wr_days = d; wr_arm = arm;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse(input bit s, input bit d);
        snooze = s; dismiss = d;
        @(negedge clk);
        snooze = 1'b0; dismiss = 1'b0;
    endtask

    initial begin
        set_time(12, 0, 0);
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ring", int'(ring), 0);
        check("rst_ring_id", int'(ring_id), 0);
        check("rst_armed", int'(armed_mask), 0);
        check("rst_snoozed", int'(snoozed_mask), 0);
        rst = 1'b0;
        @(negedge clk);

        write_ch(0, 16'h0730, 7'h7F, 1'b1);
        check("arm_ch0", int'(armed_mask), 1);
        set_time(7, 29, 59);
        @(negedge clk);
        check("pre_trigger_ring", int'(ring), 0);
        do_tick();
        check("trigger_ring", int'(ring), 1);
        check("trigger_id", int'(ring_id), 0);
        ticks(RS - 1);
        check("ring_before_timeout", int'(ring), 1);
        ticks(1);
        check("timeout_ring", int'(ring), 0);
        check("timeout_armed", int'(armed_mask), 1);

        set_time(7, 29, 59);
        do_tick();
        check("retrigger_ring", int'(ring), 1);
        for (int k = 0; k < MS; k++) begin
            pulse(1'b1, 1'b0);
            check("snooze_mask", int'(snoozed_mask), 1);
            check("snooze_ring", int'(ring), 0);
            ticks(SM * 60 - 1);
            check("snooze_still_quiet", int'(ring), 0);
            ticks(1);
            check("snooze_expiry_ring", int'(ring), 1);
        end
        pulse(1'b1, 1'b0);
        check("max_snooze_ring", int'(ring), 0);
        check("max_snooze_snoozed", int'(snoozed_mask), 0);
        check("max_snooze_armed", int'(armed_mask), 1);

        write_ch(1, 16'h0600, 7'h7F, 1'b1);
        write_ch(3, 16'h0600, 7'h7F, 1'b1);
        check("multi_armed", int'(armed_mask), 'b1011);
        set_time(5, 59, 59);
        do_tick();
        check("multi_ring", int'(ring), 1);
        check("multi_ring_id", int'(ring_id), 1);
        pulse(1'b1, 1'b1);
        check("dismiss_wins_ring", int'(ring), 0);
        check("dismiss_wins_snoozed", int'(snoozed_mask), 0);
        check("dismiss_wins_armed", int'(armed_mask), 'b1011);

        write_ch(2, 16'h2460, 7'h7F, 1'b1);
        check("bad_bcd_idle", int'(armed_mask), 'b1011);
        write_ch(3, 16'h0600, 7'h7F, 1'b0);
        check("disarm_ch3", int'(armed_mask), 'b0011);
        set_time(5, 59, 59);
        do_tick();
        check("ch1_ring", int'(ring), 1);
        write_ch(1, 16'h0600, 7'h7F, 1'b1);
        check("write_drops_ring", int'(ring), 0);
        check("write_keeps_armed", int'(armed_mask), 'b0011);

        write_ch(2, 16'h0800, 7'h00, 1'b1);
        check("zero_days_armed", int'(armed_mask), 'b0111);
        set_time(7, 59, 59);
        do_tick();
        check("zero_days_no_ring", int'(ring), 0);

        write_ch(3, 16'h0900, 7'b0000100, 1'b1);
        weekday = 3'd3;
        set_time(8, 59, 59);
        do_tick();
        check("wrong_day_no_ring", int'(ring), 0);
        weekday = 3'd2;
        set_time(8, 59, 59);
        do_tick();
        check("right_day_ring", int'(ring), 1);
        check("right_day_id", int'(ring_id), 3);

        #2 rst = 1'b1;
        #1;
        check("async_rst_ring", int'(ring), 0);
        check("async_rst_armed", int'(armed_mask), 0);
        check("async_rst_snoozed", int'(snoozed_mask), 0);
        @(negedge clk);
        rst = 1'b0;
        set_time(8, 59, 59);
        do_tick();
        check("post_rst_no_ring", int'(ring), 0);
        check("post_rst_armed", int'(armed_mask), 0);

        // Random traffic around 10:00-10:02 so alarms keep firing
        set_time(10, 0, 50);
        for (int it = 0; it < 6000; it++) begin
            tick_1hz = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 40) == 0) set_time(10, $urandom_range(0, 2), 58 + $urandom_range(0, 1));
            if (tick_1hz) advance();
            if ($urandom_range(0, 60) == 0) weekday = 3'($urandom_range(0, 6));
            wr_en = ($urandom_range(0, 25) == 0);
            wr_idx = IW'($urandom_range(0, N - 1));
            case ($urandom_range(0, 5))
                0, 1, 2: wr_time = {8'h10, to_bcd($urandom_range(0, 2))};
                3:       wr_time = 16'h2460;
                4:       wr_time = 16'($urandom());
                default: wr_time = 16'h1A00;
            endcase
            wr_days = ($urandom_range(0, 2) == 0) ? 7'($urandom()) : 7'h7F;
            wr_arm = ($urandom_range(0, 4) != 0);
            snooze = ($urandom_range(0, 40) == 0);
            dismiss = ($urandom_range(0, 90) == 0);
            rst = ($urandom_range(0, 1500) == 0);
            @(negedge clk);
        end
        tick_1hz = 1'b0; wr_en = 1'b0; snooze = 1'b0; dismiss = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
